// File: rtl/wca_cic_interpolator.sv
// wca_cic_interpolator: dual-channel I/Q CIC interpolator with shift normalisation, rounding and saturation
module wca_cic_interpolator #(
    parameter int DATA_W   = 16,
    parameter int N_STAGES = 4,
    parameter int ACC_W    = 40
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     bypass,
    input  logic                     strobe_in,
    input  logic                     strobe_out,
    input  logic [3:0]               log2_rate,
    input  logic signed [DATA_W-1:0] in_i,
    input  logic signed [DATA_W-1:0] in_q,
    output logic signed [DATA_W-1:0] out_i,
    output logic signed [DATA_W-1:0] out_q,
    output logic                     out_valid,
    output logic                     overrun
);
    localparam logic signed [ACC_W-1:0] MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] MIN = ~MAX;
    logic                     clr, flush, s_valid;
    logic [7:0]               sh;
    logic signed [ACC_W-1:0]  rnd;
    logic signed [DATA_W-1:0] sample [2];
    logic signed [DATA_W-1:0] held   [2];
    logic signed [DATA_W-1:0] result [2];
    logic signed [DATA_W-1:0] sat    [2];
    logic signed [ACC_W-1:0]  sum    [2];
    logic signed [ACC_W-1:0]  r      [2];
    logic signed [ACC_W-1:0]  c      [2][N_STAGES+1];
    logic signed [ACC_W-1:0]  d      [2][N_STAGES];
    logic signed [ACC_W-1:0]  acc    [2][N_STAGES];
    assign clr       = reset | ~enable;
    assign flush     = clr | bypass;
    assign sample[0] = in_i;
    assign sample[1] = in_q;
    assign out_i     = result[0];
    assign out_q     = result[1];
    assign sh        = 8'(N_STAGES - 1) * {4'b0000, log2_rate};
    assign rnd       = (sh != 8'd0) ? ACC_W'(1) << (sh - 8'd1) : '0;
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            sum[ch] = acc[ch][N_STAGES-1] + rnd;
            r[ch]   = sum[ch] >>> sh;
            sat[ch] = (r[ch] > MAX) ? MAX[DATA_W-1:0] : (r[ch] < MIN) ? MIN[DATA_W-1:0] : r[ch][DATA_W-1:0];
        end
    end
    // Filter state; held at zero in bypass so leaving bypass starts clean
    always_ff @(posedge clock) begin
        if (flush) begin
            s_valid <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                for (int k = 0; k <= N_STAGES; k++) c[ch][k] <= '0;
                for (int k = 0; k < N_STAGES; k++) begin
                    d[ch][k]   <= '0;
                    acc[ch][k] <= '0;
                end
            end
        end else begin
            s_valid <= strobe_in | (s_valid & ~strobe_out);
            for (int ch = 0; ch < 2; ch++) begin
                if (strobe_in) begin
                    c[ch][0] <= ACC_W'(sample[ch]);
                    for (int k = 1; k <= N_STAGES; k++) begin
                        c[ch][k]   <= c[ch][k-1] - d[ch][k-1];
                        d[ch][k-1] <= c[ch][k-1];
                    end
                end
                if (strobe_out) begin
                    acc[ch][0] <= acc[ch][0] + (s_valid ? c[ch][N_STAGES] : '0);
                    for (int k = 1; k < N_STAGES; k++) acc[ch][k] <= acc[ch][k] + acc[ch][k-1];
                end
            end
        end
    end
    always_ff @(posedge clock) begin
        if (clr) begin
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                result[ch] <= '0;
                held[ch]   <= '0;
            end
        end else begin
            out_valid <= strobe_out;
            if (strobe_in & s_valid & ~strobe_out & ~bypass) overrun <= 1'b1;
            for (int ch = 0; ch < 2; ch++) begin
                if (strobe_in & bypass) held[ch] <= sample[ch];
                if (strobe_out) result[ch] <= bypass ? held[ch] : sat[ch];
            end
        end
    end
endmodule

// File: tb/tb_wca_cic_interpolator.sv
// tb_wca_cic_interpolator: directed checks of DC gain, impulse response, saturation, overrun, bypass and reset
module tb_wca_cic_interpolator;
    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b1;
    logic               bypass = 1'b0;
    logic               strobe_in = 1'b0;
    logic               strobe_out = 1'b0;
    logic [3:0]         log2_rate = 4'd2;
    logic signed [15:0] in_i = '0;
    logic signed [15:0] in_q = '0;
    logic signed [15:0] out_i, out_q;
    logic               out_valid, overrun;
    int                 checks = 0;
    int                 errors = 0;
    int                 first_cold, first_warm;
    int                 q_ok;
    int                 imp_seen [$];
    int                 imp_exp [5] = '{2048, 8192, 12288, 8192, 2048};
    wca_cic_interpolator #(.DATA_W(16), .N_STAGES(4), .ACC_W(40)) dut (
        .clock(clock), .reset(reset), .enable(enable), .bypass(bypass),
        .strobe_in(strobe_in), .strobe_out(strobe_out), .log2_rate(log2_rate),
        .in_i(in_i), .in_q(in_q), .out_i(out_i), .out_q(out_q),
        .out_valid(out_valid), .overrun(overrun)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic tick(input logic si, input logic so);
        strobe_in = si;
        strobe_out = so;
        @(posedge clock);
        #1;
        strobe_in = 1'b0;
        strobe_out = 1'b0;
    endtask
    // strobe_out every third cycle, optional strobe_in the cycle before it
    task automatic out_step(input logic si);
        tick(1'b0, 1'b0);
        tick(si, 1'b0);
        tick(1'b0, 1'b1);
    endtask
    task automatic restart(input logic [3:0] l2);
        enable = 1'b0;
        log2_rate = l2;
        tick(1'b0, 1'b0);
        enable = 1'b1;
    endtask
    task automatic run_dc(input int n, output int first);
        first = -1;
        for (int j = 0; j < n; j++) begin
            out_step(j % 4 == 0);
            if (first < 0 && out_i == 16'sd1000 && out_q == -16'sd1000) first = j;
        end
    endtask
    initial begin
        tick(1'b0, 1'b1);
        check("reset_out_i", out_i, 0);
        check("reset_out_q", out_q, 0);
        check("reset_valid", out_valid, 0);
        check("reset_overrun", overrun, 0);
        reset = 1'b0;
        tick(1'b0, 1'b0);
        in_i = 16'sd1000;
        in_q = -16'sd1000;
        run_dc(60, first_cold);
        check("dc_settle_bound", (first_cold > 0 && first_cold <= 55), 1);
        for (int j = 0; j < 8; j++) begin
            out_step(j % 4 == 0);
            check("dc_out_i", out_i, 1000);
            check("dc_out_q", out_q, -1000);
            check("dc_valid", out_valid, 1);
        end
        tick(1'b0, 1'b0);
        check("dc_valid_low", out_valid, 0);
        reset = 1'b1;
        tick(1'b0, 1'b1);
        check("midreset_out_i", out_i, 0);
        check("midreset_out_q", out_q, 0);
        check("midreset_valid", out_valid, 0);
        reset = 1'b0;
        tick(1'b0, 1'b0);
        run_dc(60, first_warm);
        check("dc_relatency", first_warm, first_cold);
        check("dc_resettled", out_i, 1000);
        in_q = '0;
        in_i = 16'sd16384;
        restart(4'd1);
        q_ok = 1;
        for (int j = 0; j < 40; j++) begin
            out_step(j % 2 == 0);
            in_i = '0;
            if (out_i != 0) imp_seen.push_back(int'(out_i));
            if (out_q != 0) q_ok = 0;
        end
        check("imp_count", imp_seen.size(), 5);
        for (int k = 0; k < 5; k++) check("imp_value", (imp_seen.size() > k) ? imp_seen[k] : -1, imp_exp[k]);
        check("imp_final_zero", out_i, 0);
        check("imp_q_quiet", q_ok, 1);
        in_i = 16'sd32000;
        in_q = -16'sd32000;
        restart(4'd1);
        for (int j = 0; j < 60; j++) out_step(j % 3 == 0);
        check("sat_pos_i", out_i, 32767);
        check("sat_neg_q", out_q, -32768);
        in_i = -16'sd32000;
        in_q = 16'sd32000;
        for (int j = 0; j < 60; j++) out_step(j % 3 == 0);
        check("sat_neg_i", out_i, -32768);
        check("sat_pos_q", out_q, 32767);
        check("sat_no_overrun", overrun, 0);
        in_i = 16'sd500;
        in_q = 16'sd500;
        restart(4'd2);
        check("ovr_clear", overrun, 0);
        tick(1'b1, 1'b0);
        check("ovr_first_in", overrun, 0);
        tick(1'b1, 1'b0);
        check("ovr_set", overrun, 1);
        for (int j = 0; j < 8; j++) out_step(j % 4 == 0);
        check("ovr_sticky", overrun, 1);
        enable = 1'b0;
        tick(1'b0, 1'b1);
        check("ovr_disable", overrun, 0);
        check("ovr_disable_out", out_i, 0);
        check("ovr_disable_valid", out_valid, 0);
        enable = 1'b1;
        restart(4'd2);
        bypass = 1'b1;
        in_i = 16'sh1234;
        in_q = -16'sd5;
        tick(1'b1, 1'b0);
        check("byp_no_valid", out_valid, 0);
        check("byp_not_yet", out_i, 0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("byp_out_i", out_i, 16'sh1234);
        check("byp_out_q", out_q, -5);
        check("byp_valid", out_valid, 1);
        tick(1'b0, 1'b0);
        check("byp_valid_pulse", out_valid, 0);
        check("byp_hold_out", out_i, 16'sh1234);
        in_i = 16'sh0abc;
        tick(1'b1, 1'b1);
        check("byp_simul_old", out_i, 16'sh1234);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("byp_simul_new", out_i, 16'sh0abc);
        check("byp_no_overrun", overrun, 0);
        bypass = 1'b0;
        in_i = '0;
        tick(1'b0, 1'b1);
        check("byp_exit_clean", out_i, 0);
        tick(1'b0, 1'b1);
        check("byp_exit_clean_q", out_q, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
